// File: rtl/card_arb_pkg.sv
// Shared types and default widths for the card-image RAM port arbiter.
package card_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int CARD_ADDR_W      = 14;
  localparam int CARD_DATA_W      = 3;
  localparam int CARD_BURST_CNT_W = 8;

endpackage

// File: rtl/card_rr_pick.sv
// Rotate-priority picker: first valid requester at or after start, wrapping N-1 -> 0.
module card_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  function automatic int slot(input int s, input int k);
    return (s + k) % N;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // Walk from farthest to nearest so the slot closest to start wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[slot(int'(start), k)]) begin
        grant                       = '0;
        grant[slot(int'(start), k)] = 1'b1;
        idx                         = IDX_W'(slot(int'(start), k));
        found                       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/card_ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between NUM_REQ requesters, with bounded burst lock.
// Optional CARD_ARB_VGA_PRIO_EN: requester 0 gets strict priority and preempts bursts.
module card_ram_port_arbiter
  import card_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = CARD_ADDR_W,
  parameter int DATA_W    = CARD_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef CARD_ARB_VGA_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  arb_state_t                  state;
  logic [IDX_W-1:0]            owner;
  logic [IDX_W-1:0]            rr_ptr;
  logic [CARD_BURST_CNT_W-1:0] burst_cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic               granted;
  logic               prio_hit;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  card_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .start (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    grant    = '0;
    gidx     = '0;
    granted  = 1'b0;
    prio_hit = PRIO_EN && req_valid[0];
    if (prio_hit) begin
      grant[0] = 1'b1;
      granted  = 1'b1;
    end else if (state == BURST) begin
      if (req_valid[owner]) begin
        grant[owner] = 1'b1;
        gidx         = owner;
        granted      = 1'b1;
      end
    end else begin
      grant   = pick_grant;
      gidx    = pick_idx;
      granted = pick_found;
    end
  end

  assign req_ready = grant;
  assign ram_we    = granted && req_we[gidx];
  assign ram_addr  = granted ? req_addr[int'(gidx)*ADDR_W +: ADDR_W] : '0;
  assign ram_wdata = granted ? req_wdata[int'(gidx)*DATA_W +: DATA_W] : '0;
  assign rsp_data  = ram_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rsp_valid <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rsp_valid <= grant & ~req_we;
      if (prio_hit) begin
        // A priority grant never moves rr_ptr; it only cancels a running burst.
        state     <= IDLE;
        burst_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (granted) begin
              rr_ptr <= next_idx(gidx);
              if (req_lock[gidx] && MAX_BURST > 1) begin
                state     <= BURST;
                owner     <= gidx;
                burst_cnt <= CARD_BURST_CNT_W'(1);
              end
            end
          end
          BURST: begin
            // Leave once this grant is the last one allowed or the owner lets go.
            if (!granted || !req_lock[owner] || int'(burst_cnt) + 1 >= MAX_BURST) begin
              state     <= IDLE;
              rr_ptr    <= next_idx(owner);
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_ram_port_arbiter.sv
// Self-checking bench for card_ram_port_arbiter against a behavioural grant/RAM model.
module tb_card_ram_port_arbiter;

  localparam int N     = 3;
  localparam int AW    = 14;
  localparam int DW    = 3;
  localparam int MAXB  = 4;
  localparam int BUS_W = N + 1 + AW + DW;
  localparam int RSP_W = N + DW;

`ifdef CARD_ARB_VGA_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  card_ram_port_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MAXB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  // Card-image RAM port A: registered read, one cycle latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_rr, m_owner, m_len;
  logic [N-1:0]  m_rsp;
  logic [DW-1:0] m_rsp_data;
  int            checks, passed;

  task automatic model_reset();
    m_rr    = 0;
    m_owner = -1;
    m_len   = 0;
    m_rsp   = '0;
  endtask

  function automatic int model_winner();
    if (PRIO && req_valid[0]) return 0;
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic logic [BUS_W-1:0] model_bus();
    int w;
    logic [N-1:0] oh;
    w  = model_winner();
    oh = '0;
    if (w < 0) return '0;
    oh[w] = 1'b1;
    return {oh, req_we[w], req_addr[w*AW +: AW], req_wdata[w*DW +: DW]};
  endfunction

  function automatic logic [RSP_W-1:0] model_rsp();
    return {m_rsp, (m_rsp != '0) ? m_rsp_data : {DW{1'b0}}};
  endfunction

  function automatic logic [BUS_W-1:0] bus_obs();
    return {req_ready, ram_we, ram_addr, ram_wdata};
  endfunction

  function automatic logic [RSP_W-1:0] rsp_obs();
    return {rsp_valid, (rsp_valid != '0) ? rsp_data : {DW{1'b0}}};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_commit();
    int w;
    w     = model_winner();
    m_rsp = '0;
    if (w >= 0) begin
      if (req_we[w]) ref_mem[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
      else begin
        m_rsp[w]   = 1'b1;
        m_rsp_data = ref_mem[req_addr[w*AW +: AW]];
      end
    end
    if (PRIO && req_valid[0]) begin
      m_owner = -1;
    end else if (m_owner >= 0) begin
      m_len++;
      if (w < 0 || !req_lock[m_owner] || m_len >= MAXB) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (w >= 0) begin
      m_rr = (w + 1) % N;
      if (req_lock[w] && MAXB > 1) begin
        m_owner = w;
        m_len   = 1;
      end
    end
  endtask

  task automatic set_reads(input logic [N-1:0] v, input logic [N-1:0] l);
    req_valid = v;
    req_lock  = l;
    req_we    = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(5 + i);
  endtask

  task automatic test_reset();
    set_reads('1, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid);
    else passed++;
    checks++;
    if (req_ready !== 3'b001) $display("FAIL reset_ready got=%b exp=001", req_ready);
    else passed++;
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] exp_oh;
    set_reads('1, '0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      exp_oh = PRIO ? 3'b001 : 3'(1 << (i % N));
      checks++;
      if (req_ready !== exp_oh) $display("FAIL rr_order cyc=%0d got=%b exp=%b", i, req_ready, exp_oh);
      else passed++;
      checks++;
      if (bus_obs() !== model_bus()) $display("FAIL rr_bus cyc=%0d got=%h exp=%h", i, bus_obs(), model_bus());
      else passed++;
      checks++;
      if (rsp_obs() !== model_rsp()) $display("FAIL rr_rsp cyc=%0d got=%h exp=%h", i, rsp_obs(), model_rsp());
      else passed++;
      model_commit();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_write_read();
    // Cycle 0: req1 writes; cycle 1: req2 reads back; cycle 2: idle.
    for (int i = 0; i < 3; i++) begin
      req_lock = '0;
      req_valid = (i == 0) ? 3'b010 : (i == 1) ? 3'b100 : 3'b000;
      req_we    = (i == 0) ? 3'b010 : 3'b000;
      req_addr[1*AW +: AW]  = 14'h1234;
      req_addr[2*AW +: AW]  = 14'h1234;
      req_wdata[1*DW +: DW] = 3'b101;
      @(negedge clock);
      checks++;
      if (bus_obs() !== model_bus()) $display("FAIL wr_bus cyc=%0d got=%h exp=%h", i, bus_obs(), model_bus());
      else passed++;
      if (i == 2) begin
        checks++;
        if ({rsp_valid, rsp_data} !== {3'b100, 3'b101})
          $display("FAIL wr_readback got=%b/%b exp=100/101", rsp_valid, rsp_data);
        else passed++;
      end
      model_commit();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_burst_cap();
    int exp_seq [12] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
    set_reads(3'b110, 3'b010);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== 3'(1 << exp_seq[i]))
        $display("FAIL burst_order cyc=%0d got=%b exp=%b", i, req_ready, 3'(1 << exp_seq[i]));
      else passed++;
      checks++;
      if (rsp_obs() !== model_rsp()) $display("FAIL burst_rsp cyc=%0d got=%h exp=%h", i, rsp_obs(), model_rsp());
      else passed++;
      model_commit();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    set_reads(3'b110, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus_obs() !== model_bus()) $display("FAIL midrst_bus cyc=%0d got=%h exp=%h", i, bus_obs(), model_bus());
      else passed++;
      model_commit();
      @(posedge clock);
      #1;
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 3'b000) $display("FAIL midrst_rsp got=%b exp=000", rsp_valid);
    else passed++;
    @(negedge clock);
    set_reads('1, '0);
    #1;
    checks++;
    if (req_ready !== 3'b001) $display("FAIL midrst_idle got=%b exp=001", req_ready);
    else passed++;
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus_obs() !== model_bus()) $display("FAIL midrst_rr cyc=%0d got=%h exp=%h", i, bus_obs(), model_bus());
      else passed++;
      checks++;
      if (rsp_obs() !== model_rsp()) $display("FAIL midrst_rsp2 cyc=%0d got=%h exp=%h", i, rsp_obs(), model_rsp());
      else passed++;
      model_commit();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_preempt();
    for (int i = 0; i < 6; i++) begin
      set_reads((i == 3) ? 3'b101 : 3'b100, 3'b100);
      @(negedge clock);
      if (i == 3) begin
        checks++;
        if (req_ready !== (PRIO ? 3'b001 : 3'b100))
          $display("FAIL preempt_grant got=%b exp=%b", req_ready, PRIO ? 3'b001 : 3'b100);
        else passed++;
      end
      checks++;
      if (bus_obs() !== model_bus()) $display("FAIL preempt_bus cyc=%0d got=%h exp=%h", i, bus_obs(), model_bus());
      else passed++;
      model_commit();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      req_lock  = N'($urandom) | N'($urandom);
      req_we    = N'($urandom) & N'($urandom);
      for (int r = 0; r < N; r++) begin
        req_addr[r*AW +: AW]  = AW'($urandom_range(0, 15));
        req_wdata[r*DW +: DW] = DW'($urandom);
      end
      @(negedge clock);
      checks++;
      if (bus_obs() !== model_bus()) $display("FAIL rand_bus cyc=%0d got=%h exp=%h", i, bus_obs(), model_bus());
      else passed++;
      checks++;
      if (rsp_obs() !== model_rsp()) $display("FAIL rand_rsp cyc=%0d got=%h exp=%h", i, rsp_obs(), model_rsp());
      else passed++;
      model_commit();
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    checks = 0;
    passed = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      v          = DW'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    model_reset();
    test_reset();
    test_rr_fairness();
    test_write_read();
    test_burst_cap();
    test_reset_mid_burst();
    test_preempt();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
